// File: rtl/watch_time_counter.sv
// Time-of-day counter (binary h:m:s, 24-hour style) driven by the clk_seconds square wave.
// Define WATCH_ALARM_EN to add the hour/minute alarm compare and its ports.
module watch_time_counter #(
    parameter int HOURS_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_seconds,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic       set_err,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       min_tick,
    output logic       day_tick
`ifdef WATCH_ALARM_EN
    ,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic       alarm
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [4:0] HOURS_LAST  = 5'(HOURS_MAX);
    localparam logic [5:0] MINSEC_LAST = 6'd59;

    state_t     state;
    logic       sec_q;
    logic       tick_q;
    logic       sec_tick;
    logic       handshake;
    logic       set_in_range;
    logic [4:0] hold_hours;
    logic [5:0] hold_minutes;
    logic [5:0] hold_seconds;

    logic       sec_wrap;
    logic       min_wrap;
    logic       hour_wrap;
    logic       day_wrap;
    logic [4:0] next_hours;
    logic [5:0] next_minutes;
    logic [5:0] next_seconds;

    assign sec_tick     = clk_seconds & ~sec_q;
    assign handshake    = set_valid & set_ready;
    assign set_in_range = (set_hours <= HOURS_LAST) &&
                          (set_minutes <= MINSEC_LAST) &&
                          (set_seconds <= MINSEC_LAST);

    // Terminal compares use >= so a corrupted out-of-range value snaps back to 0.
    always_comb begin
        sec_wrap     = (seconds >= MINSEC_LAST);
        min_wrap     = (minutes >= MINSEC_LAST);
        hour_wrap    = (hours >= HOURS_LAST);
        day_wrap     = sec_wrap & min_wrap & hour_wrap;
        next_seconds = sec_wrap ? 6'd0 : seconds + 6'd1;
        next_minutes = (minutes > MINSEC_LAST) ? 6'd0 : minutes;
        next_hours   = (hours > HOURS_LAST) ? 5'd0 : hours;
        if (sec_wrap) begin
            next_minutes = min_wrap ? 6'd0 : minutes + 6'd1;
            if (min_wrap) begin
                next_hours = hour_wrap ? 5'd0 : hours + 5'd1;
            end
        end
    end

`ifdef WATCH_ALARM_EN
    logic alarm_hit;
    assign alarm_hit = (next_hours == alarm_hours) &&
                       (next_minutes == alarm_minutes) &&
                       (next_seconds == 6'd0);
`endif

    // The detected edge is pipelined once; ticks seen in the handshake or LOAD
    // cycle are dropped here so the loaded time is never bumped afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            sec_q        <= 1'b0;
            tick_q       <= 1'b0;
            set_ready    <= 1'b1;
            set_err      <= 1'b0;
            hours        <= 5'd0;
            minutes      <= 6'd0;
            seconds      <= 6'd0;
            min_tick     <= 1'b0;
            day_tick     <= 1'b0;
            hold_hours   <= 5'd0;
            hold_minutes <= 6'd0;
            hold_seconds <= 6'd0;
`ifdef WATCH_ALARM_EN
            alarm        <= 1'b0;
`endif
        end else begin
            sec_q    <= clk_seconds;
            tick_q   <= sec_tick & (state == RUN) & ~handshake;
            min_tick <= 1'b0;
            day_tick <= 1'b0;
`ifdef WATCH_ALARM_EN
            alarm    <= 1'b0;
`endif
            case (state)
                RUN: begin
                    if (handshake) begin
                        hold_hours   <= set_hours;
                        hold_minutes <= set_minutes;
                        hold_seconds <= set_seconds;
                        set_err      <= ~set_in_range;
                        set_ready    <= 1'b0;
                        state        <= LOAD;
                    end else if (tick_q) begin
                        hours    <= next_hours;
                        minutes  <= next_minutes;
                        seconds  <= next_seconds;
                        min_tick <= sec_wrap;
                        day_tick <= day_wrap;
`ifdef WATCH_ALARM_EN
                        alarm    <= alarm_hit;
`endif
                    end
                end
                LOAD: begin
                    // set_err already holds the range verdict taken at capture.
                    if (!set_err) begin
                        hours   <= hold_hours;
                        minutes <= hold_minutes;
                        seconds <= hold_seconds;
                    end
                    set_err   <= 1'b0;
                    set_ready <= 1'b1;
                    state     <= RUN;
                end
                default: begin
                    set_err   <= 1'b0;
                    set_ready <= 1'b1;
                    state     <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed self-checking bench for watch_time_counter with hand-computed expectations.
// Alarm steps are compiled in only when WATCH_ALARM_EN is defined.
module tb_watch_time_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_seconds = 1'b0;
    logic       set_valid = 1'b0;
    logic       set_ready;
    logic [4:0] set_hours = 5'd0;
    logic [5:0] set_minutes = 6'd0;
    logic [5:0] set_seconds = 6'd0;
    logic       set_err;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       min_tick;
    logic       day_tick;
`ifdef WATCH_ALARM_EN
    logic [4:0] alarm_hours = 5'd6;
    logic [5:0] alarm_minutes = 6'd30;
    logic       alarm;
`endif

    int total = 0;
    int bad = 0;

    watch_time_counter #(.HOURS_MAX(23)) dut (
        .clk(clk),
        .reset(reset),
        .clk_seconds(clk_seconds),
        .set_valid(set_valid),
        .set_ready(set_ready),
        .set_hours(set_hours),
        .set_minutes(set_minutes),
        .set_seconds(set_seconds),
        .set_err(set_err),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .min_tick(min_tick),
        .day_tick(day_tick)
`ifdef WATCH_ALARM_EN
        ,
        .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm(alarm)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_time(input string tag, input logic [4:0] h,
                              input logic [5:0] m, input logic [5:0] s);
        total++;
        assert ({hours, minutes, seconds} === {h, m, s}) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d:%0d:%0d expected=%0d:%0d:%0d",
                   tag, hours, minutes, seconds, h, m, s);
        end
    endtask

    // One clk_seconds period of two clocks; counters update one clock after the sampled edge.
    task automatic apply_tick();
        clk_seconds = 1'b1;
        step();
        clk_seconds = 1'b0;
        step();
    endtask

    // Handshake cycle, then the single LOAD cycle; returns after the load has landed.
    task automatic apply_load(input string tag, input logic [4:0] h, input logic [5:0] m,
                              input logic [5:0] s, input logic expect_err);
        set_hours   = h;
        set_minutes = m;
        set_seconds = s;
        set_valid   = 1'b1;
        step();
        set_valid = 1'b0;
        check_bit({tag, "_ready_low"}, set_ready, 1'b0);
        check_bit({tag, "_err"}, set_err, expect_err);
        step();
        check_bit({tag, "_ready_high"}, set_ready, 1'b1);
        check_bit({tag, "_err_clear"}, set_err, 1'b0);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        check_time("reset_time", 5'd0, 6'd0, 6'd0);
        check_bit("reset_ready", set_ready, 1'b1);
        check_bit("reset_err", set_err, 1'b0);
        check_bit("reset_min_tick", min_tick, 1'b0);
        check_bit("reset_day_tick", day_tick, 1'b0);
        step();

        // First tick with its latency visible: no change one clock after the sample.
        clk_seconds = 1'b1;
        step();
        check_time("tick1_not_yet", 5'd0, 6'd0, 6'd0);
        clk_seconds = 1'b0;
        step();
        check_time("tick1", 5'd0, 6'd0, 6'd1);
        check_bit("tick1_min_tick", min_tick, 1'b0);
        apply_tick();
        check_time("tick2", 5'd0, 6'd0, 6'd2);
        apply_tick();
        check_time("tick3", 5'd0, 6'd0, 6'd3);
        check_bit("tick3_min_tick", min_tick, 1'b0);

        // Minute and hour carry.
        apply_load("load_125958", 5'd12, 6'd59, 6'd58, 1'b0);
        check_time("load_125958_time", 5'd12, 6'd59, 6'd58);
        apply_tick();
        check_time("t_125959", 5'd12, 6'd59, 6'd59);
        check_bit("t_125959_min_tick", min_tick, 1'b0);
        apply_tick();
        check_time("t_130000", 5'd13, 6'd0, 6'd0);
        check_bit("t_130000_min_tick", min_tick, 1'b1);
        check_bit("t_130000_day_tick", day_tick, 1'b0);
        step();
        check_bit("min_tick_one_cycle", min_tick, 1'b0);
        check_time("t_130000_hold", 5'd13, 6'd0, 6'd0);

        // Day rollover.
        apply_load("load_235959", 5'd23, 6'd59, 6'd59, 1'b0);
        check_time("load_235959_time", 5'd23, 6'd59, 6'd59);
        apply_tick();
        check_time("day_wrap", 5'd0, 6'd0, 6'd0);
        check_bit("day_wrap_min_tick", min_tick, 1'b1);
        check_bit("day_wrap_day_tick", day_tick, 1'b1);
        step();
        check_bit("day_tick_one_cycle", day_tick, 1'b0);

        // Rejected loads leave the time alone.
        apply_load("load_h24", 5'd24, 6'd0, 6'd0, 1'b1);
        check_time("load_h24_time", 5'd0, 6'd0, 6'd0);
        apply_load("load_m61", 5'd7, 6'd61, 6'd0, 1'b1);
        check_time("load_m61_time", 5'd0, 6'd0, 6'd0);
        apply_load("load_s60", 5'd1, 6'd0, 6'd60, 1'b1);
        check_time("load_s60_time", 5'd0, 6'd0, 6'd0);

        // Tick coinciding with the handshake is discarded.
        apply_load("load_050010", 5'd5, 6'd0, 6'd10, 1'b0);
        check_time("load_050010_time", 5'd5, 6'd0, 6'd10);
        clk_seconds = 1'b1;
        set_hours   = 5'd9;
        set_minutes = 6'd30;
        set_seconds = 6'd0;
        set_valid   = 1'b1;
        step();
        set_valid = 1'b0;
        step();
        check_time("coincide_loaded", 5'd9, 6'd30, 6'd0);
        clk_seconds = 1'b0;
        step();
        step();
        check_time("coincide_no_extra", 5'd9, 6'd30, 6'd0);
        apply_tick();
        check_time("coincide_next_tick", 5'd9, 6'd30, 6'd1);

        // Tick arriving during the LOAD cycle is discarded as well.
        set_hours   = 5'd2;
        set_minutes = 6'd0;
        set_seconds = 6'd0;
        set_valid   = 1'b1;
        step();
        set_valid   = 1'b0;
        clk_seconds = 1'b1;
        step();
        clk_seconds = 1'b0;
        step();
        step();
        check_time("load_cycle_tick_dropped", 5'd2, 6'd0, 6'd0);

`ifdef WATCH_ALARM_EN
        apply_load("load_062959", 5'd6, 6'd29, 6'd59, 1'b0);
        check_bit("alarm_idle", alarm, 1'b0);
        apply_tick();
        check_time("alarm_time", 5'd6, 6'd30, 6'd0);
        check_bit("alarm_fire", alarm, 1'b1);
        step();
        check_bit("alarm_one_cycle", alarm, 1'b0);
        set_hours   = 5'd6;
        set_minutes = 6'd30;
        set_seconds = 6'd0;
        set_valid   = 1'b1;
        step();
        set_valid = 1'b0;
        check_bit("alarm_load_handshake", alarm, 1'b0);
        step();
        check_bit("alarm_load_landed", alarm, 1'b0);
        step();
        check_bit("alarm_load_after", alarm, 1'b0);
`endif

        // Reset during LOAD abandons the load.
        set_hours   = 5'd3;
        set_minutes = 6'd0;
        set_seconds = 6'd0;
        set_valid   = 1'b1;
        step();
        set_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_time("midload_reset_time", 5'd0, 6'd0, 6'd0);
        check_bit("midload_reset_ready", set_ready, 1'b1);
        reset = 1'b0;
        step();
        step();
        check_time("midload_abandoned", 5'd0, 6'd0, 6'd0);
        check_bit("midload_ready_after", set_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/watch_time_counter.md
# watch_time_counter

Time-of-day counter for the watch chip. It consumes the `clk_seconds` square wave from the clock divider, detects one rising edge per second, and maintains binary seconds, minutes and hours in 24-hour format. A ready/valid load port sets the time, and an optional alarm compare can be compiled in. Its outputs feed the display driver.

## Interface
Parameters:
- `HOURS_MAX`, default 23: last hour value before the day rolls over (23 gives a 24-hour clock).

Ports:
- `clk` input 1: system clock. Same domain as `clk_seconds`.
- `reset` input 1: asynchronous, active-high reset.
- `clk_seconds` input 1: square wave from the divider. One rising edge marks one second.
- `set_valid` input 1: load request.
- `set_ready` output 1: counter can accept a load.
- `set_hours` input 5: load value for hours.
- `set_minutes` input 6: load value for minutes.
- `set_seconds` input 6: load value for seconds.
- `set_err` output 1: one-cycle pulse when a load was rejected as out of range.
- `hours` output 5: current hours, 0..HOURS_MAX.
- `minutes` output 6: current minutes, 0..59.
- `seconds` output 6: current seconds, 0..59.
- `min_tick` output 1: one-cycle pulse when seconds wraps 59->0.
- `day_tick` output 1: one-cycle pulse when the time wraps HOURS_MAX:59:59 -> 0:00:00.
- `alarm_hours` input 5: alarm hour. Present only with ALARM_EN.
- `alarm_minutes` input 6: alarm minute. Present only with ALARM_EN.
- `alarm` output 1: alarm pulse. Present only with ALARM_EN.

## Operation
- Edge detect:
  - Register `clk_seconds` into `sec_q`.
  - `sec_tick = clk_seconds & ~sec_q`.
- FSM has two states, RUN and LOAD. Reset state is RUN.
- RUN:
  - `set_ready` = 1.
  - On `sec_tick`, increment the time:
    - seconds 59 -> 0, carry into minutes.
    - minutes 59 -> 0, carry into hours.
    - hours HOURS_MAX -> 0.
  - On `set_valid & set_ready`, go to LOAD and capture the three `set_*` values into holding registers.
- LOAD lasts exactly one cycle:
  - `set_ready` = 0.
  - Range check: hours <= HOURS_MAX, minutes <= 59, seconds <= 59.
  - Pass: copy holding registers into the counters.
  - Fail: counters keep their values and `set_err` pulses for this cycle.
  - Then return to RUN.
- Ticks not accepted during LOAD:
  - A `sec_tick` in the handshake cycle or in the LOAD cycle is discarded. The loaded time is authoritative.
  - `sec_q` keeps updating, so no spurious tick follows.
- `min_tick` and `day_tick` are registered and asserted in the same cycle the wrapped values appear.
- Arithmetic:
  - Plain binary; no BCD.
  - Compare against the terminal value before incrementing, so no out-of-range value ever appears.
- Counter values outside range, reachable only via X or glitches, wrap to 0 on the next tick.
- Reset mid-LOAD: the load is abandoned and the FSM returns to RUN.

## Timing
- Reset values:
  - `hours`, `minutes`, `seconds` = 0.
  - `set_ready` = 1.
  - `set_err`, `min_tick`, `day_tick`, `alarm` = 0.
  - `sec_q` = 0.
  - FSM in RUN.
- Tick latency: a rising edge of `clk_seconds` sampled at clock edge N updates the counters at edge N+1.
- Load latency: a handshake at edge N moves the FSM to LOAD; the outputs show the loaded time after edge N+1.
- Minimum spacing between loads is 2 cycles, because `set_ready` is low during LOAD.
- Tick throughput is one per `clk_seconds` period. The divider guarantees a period of at least 2 clk cycles.

## Configuration
- `WATCH_ALARM_EN` defined:
  - The `alarm_hours`, `alarm_minutes` and `alarm` ports exist.
  - `alarm` pulses for one cycle when a tick-driven update produces hours == `alarm_hours`, minutes == `alarm_minutes` and seconds == 0.
  - A load that lands exactly on the alarm time does not fire the alarm.
- `WATCH_ALARM_EN` undefined:
  - The alarm ports and logic are absent.
  - Everything else is identical.

## Test plan
- Reset, then 3 `clk_seconds` rising edges -> seconds 0->1->2->3. Each update lands 1 cycle after its edge; `min_tick` stays 0.
- Load 12:59:58 and apply 2 ticks:
  - After the first tick: 12:59:59.
  - After the second tick: 13:00:00, with `min_tick` = 1 for exactly one cycle.
- Load 23:59:59 and apply 1 tick -> 00:00:00, with `min_tick` = 1 and `day_tick` = 1 in the same cycle.
- Load 24:00:00 -> `set_err` pulses 1 cycle and the time is unchanged. Then load 7:61:00 -> `set_err` pulses and the time is unchanged.
- `set_valid` coincides with `sec_tick` while the time is 5:00:10, load value 9:30:00 -> outputs 9:30:00, no extra increment. The next tick gives 9:30:01.
- With `WATCH_ALARM_EN`: alarm set to 6:30, load 6:29:59, apply 1 tick -> `alarm` = 1 for one cycle at 6:30:00. Loading 6:30:00 directly -> `alarm` stays 0.
